// File: rtl/div_arb_pkg.sv
// Shared types, constants and the round-robin pick function for div_arbiter.
package div_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Default number of cycles waited for div_done before a timeout.
  localparam int unsigned DEF_TIMEOUT_LIMIT = 64;

  // Widest requester vector the pick function handles.
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned MAX_ID_W = 3;

  // First set req bit at or after ptr, wrapping modulo nof_req; 0 when no bit is set.
  function automatic logic [MAX_ID_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  req,
    input logic [MAX_ID_W-1:0] ptr,
    input int unsigned         nof_req
  );
    logic [MAX_ID_W-1:0] win;
    logic                found;
    logic [MAX_ID_W:0]   idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      // ptr < nof_req and i < nof_req, so one subtraction is enough to wrap.
      idx = {1'b0, ptr} + (MAX_ID_W + 1)'(i);
      if (idx >= (MAX_ID_W + 1)'(nof_req)) idx = idx - (MAX_ID_W + 1)'(nof_req);
      if (!found && (i < nof_req) && req[idx[MAX_ID_W-1:0]]) begin
        win   = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/div_arbiter_rr.sv
// rr_arbiter: reusable round-robin selector. The winner is combinational from
// the request vector and the pointer; the pointer moves past the winner only
// when the owner of the shared resource accepts the grant (grant_en).
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter  int unsigned NOF_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NOF_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NOF_REQ-1:0] req,
  input  logic               grant_en,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Pick the winner from the pointer and compute the post-grant pointer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    rr_ptr_d = rr_ptr_q;
    any_req  = |req;
    winner   = ID_W'(rr_pick(MAX_REQ'(req), MAX_ID_W'(rr_ptr_q), NOF_REQ));
    if (grant_en) begin
      rr_ptr_d = (winner == ID_W'(NOF_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one start/done unsigned divider among NOF_REQ requesters.
// Grants round-robin, latches the winner's operands, pulses div_start, waits for
// div_done and returns the result with a one-hot done pulse.
// Optional: define DIV_ARB_TIMEOUT_EN to abandon a divide after TIMEOUT_LIMIT
// wait cycles (TO pulses with done, results forced to 0).
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter  int unsigned NOF_BITS      = 33,
  parameter  int unsigned NOF_REQ       = 4,
  parameter  int unsigned TIMEOUT_LIMIT = DEF_TIMEOUT_LIMIT,
  localparam int unsigned ID_W          = $clog2(NOF_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NOF_REQ-1:0]          req,
  input  logic [NOF_REQ*NOF_BITS-1:0] a_in,
  input  logic [NOF_REQ*NOF_BITS-1:0] b_in,
  output logic [NOF_REQ-1:0]          done,
  output logic [NOF_BITS-1:0]         val_out,
  output logic [NOF_BITS-1:0]         rem_out,
  output logic                        dbz_out,
  output logic                        TO,
  output logic                        busy,
  output logic [ID_W-1:0]             grant_id,
  output logic                        div_start,
  output logic [NOF_BITS-1:0]         div_a,
  output logic [NOF_BITS-1:0]         div_b,
  input  logic                        div_done,
  input  logic                        div_valid,
  input  logic                        div_dbz,
  input  logic [NOF_BITS-1:0]         div_val,
  input  logic [NOF_BITS-1:0]         div_rem
);

  if (NOF_REQ < 2 || NOF_REQ > MAX_REQ) begin : g_bad_nof_req
    $error("div_arbiter: NOF_REQ must be in 2..8");
  end
  if (TIMEOUT_LIMIT < 2) begin : g_bad_timeout
    $error("div_arbiter: TIMEOUT_LIMIT must be at least 2");
  end

  state_e              state_q, state_d;
  logic [NOF_BITS-1:0] div_a_q, div_a_d;
  logic [NOF_BITS-1:0] div_b_q, div_b_d;
  logic [NOF_BITS-1:0] val_q, val_d;
  logic [NOF_BITS-1:0] rem_q, rem_d;
  logic                dbz_q, dbz_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     winner;
  logic                any_req;
  logic                grant_en;
  logic                tmo_hit;

  rr_arbiter #(.NOF_REQ(NOF_REQ)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant_en (grant_en),
    .winner   (winner),
    .any_req  (any_req)
  );

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_LIMIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             to_q, to_d;

  // Count ST_WAIT cycles; the count reaching TIMEOUT_LIMIT-1 without div_done aborts.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
    tmo_hit = (state_q == ST_WAIT) && !div_done &&
              (wait_cnt_d == CNT_W'(TIMEOUT_LIMIT - 1));
    to_d    = tmo_hit;
  end

  // Timeout counter and the TO flag that lines up with the ST_RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      to_q       <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      to_q       <= to_d;
    end
  end

  assign TO = to_q;
`else
  assign tmo_hit = 1'b0;
  assign TO      = 1'b0;
`endif

  // Next-state logic: grant in IDLE, one issue cycle, wait for the divider, respond.
  always_comb begin
    state_d    = state_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    val_d      = val_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    grant_id_d = grant_id_q;
    grant_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_en   = 1'b1;
          div_a_d    = a_in[32'(winner) * NOF_BITS +: NOF_BITS];
          div_b_d    = b_in[32'(winner) * NOF_BITS +: NOF_BITS];
          grant_id_d = winner;
          state_d    = ST_ISSUE;
        end
      end
      // div_done is not looked at here, so a done coincident with start is dropped.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (div_done) begin
          val_d   = div_val;
          rem_d   = div_rem;
          dbz_d   = div_dbz & div_valid;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          val_d   = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched operands, grant index and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_a_q    <= '0;
      div_b_q    <= '0;
      val_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      val_q      <= val_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      grant_id_q <= grant_id_d;
    end
  end

  // One-hot completion pulse to the granted requester during ST_RESP.
  always_comb begin
    done = '0;
    if (state_q == ST_RESP) done[grant_id_q] = 1'b1;
  end

  assign busy      = (state_q != ST_IDLE);
  assign div_start = (state_q == ST_ISSUE);
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign grant_id  = grant_id_q;
  assign val_out   = val_q;
  assign rem_out   = rem_q;
  assign dbz_out   = dbz_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: a behavioural divider with programmable
// latency, a requester model that drops req on its done pulse, and a scoreboard
// of expected completions popped on every done pulse.
module tb_div_arbiter;

  localparam int unsigned NB = 33;
  localparam int unsigned NR = 4;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*NB-1:0] a_in, b_in;
  logic [NR-1:0]    done;
  logic [NB-1:0]    val_out, rem_out;
  logic             dbz_out, to_o, busy;
  logic [1:0]       grant_id;
  logic             div_start;
  logic [NB-1:0]    div_a, div_b;
  logic             div_done, div_valid, div_dbz;
  logic [NB-1:0]    div_val, div_rem;

  div_arbiter #(.NOF_BITS(NB), .NOF_REQ(NR), .TIMEOUT_LIMIT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .done      (done),
    .val_out   (val_out),
    .rem_out   (rem_out),
    .dbz_out   (dbz_out),
    .TO        (to_o),
    .busy      (busy),
    .grant_id  (grant_id),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_done  (div_done),
    .div_valid (div_valid),
    .div_dbz   (div_dbz),
    .div_val   (div_val),
    .div_rem   (div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NR-1:0] done;
    logic [NB-1:0] q;
    logic [NB-1:0] r;
    logic          dbz;
    logic          to;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input int id, input logic [NB-1:0] q, input logic [NB-1:0] r,
                          input logic dbz, input logic to);
    exp_t e;
    e.done     = '0;
    e.done[id] = 1'b1;
    e.q        = q;
    e.r        = r;
    e.dbz      = dbz;
    e.to       = to;
    exp_q.push_back(e);
  endtask

  task automatic set_ops(input int id, input logic [NB-1:0] a, input logic [NB-1:0] b);
    a_in[id*NB +: NB] = a;
    b_in[id*NB +: NB] = b;
  endtask

  // ---------------- divider model ----------------
  // Accepts start at a clock edge, computes for lat cycles, pulses done the cycle after.
  // Divide by zero returns all-ones quotient and the dividend as remainder.
  int            lat = 5;
  bit            mute = 1'b0;
  bit            late = 1'b0;
  int            m_cnt;
  logic [NB-1:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_a   <= '0;
      m_b   <= '0;
    end else if (div_start) begin
      m_cnt <= lat + 1;
      m_a   <= div_a;
      m_b   <= div_b;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always_comb begin
    div_done  = (!mute && m_cnt == 1) || late;
    div_valid = div_done;
    div_dbz   = (m_b == '0);
    div_val   = (m_b == '0) ? '1 : m_a / m_b;
    div_rem   = (m_b == '0) ? m_a : m_a % m_b;
  end

  // ---------------- monitor / requester model ----------------
  bit auto_drop = 1'b1;
  bit start_prev = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (div_start) check("start_single_no_overlap", {start_prev, m_cnt != 0}, 0);
      start_prev = div_start;
      if (done != '0) begin
        check("busy_on_done", busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_onehot", done, e.done);
          check("result_q_r_dbz_to", {val_out, rem_out, dbz_out, to_o}, {e.q, e.r, e.dbz, e.to});
        end
        if (auto_drop) req = req & ~done;
      end
    end else begin
      start_prev = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((exp_q.size() != 0 || busy) && n < budget);
    check({name, "_drained"}, {exp_q.size() != 0, busy}, 0);
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (!div_start && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_start_seen"}, div_start, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int            id;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NB-1:0] q;
    logic [NB-1:0] r;
    logic          dbz;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int busy_cnt;
    int done_at;

    tbl[0] = '{0, 33'd100,          33'd7,          33'd14,         33'd2,     1'b0};
    tbl[1] = '{1, 33'd0,            33'd5,          33'd0,          33'd0,     1'b0};
    tbl[2] = '{2, 33'h1_FFFF_FFFF,  33'd1,          33'h1_FFFF_FFFF, 33'd0,    1'b0};
    tbl[3] = '{3, 33'd12345,        33'd0,          33'h1_FFFF_FFFF, 33'd12345, 1'b1};
    tbl[4] = '{1, 33'd5,            33'd9,          33'd0,          33'd5,     1'b0};
    tbl[5] = '{2, 33'h1_0000_0000,  33'h1_0000_0000, 33'd1,         33'd0,     1'b0};
    tbl[6] = '{0, 33'd1000000,      33'd3,          33'd333333,     33'd1,     1'b0};

    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          {done, val_out, rem_out, dbz_out, to_o, busy, grant_id, div_start, div_a, div_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, divider latency 5: start the cycle after the grant edge,
    // done in the 8th busy cycle.
    lat = 5;
    @(negedge clk);
    set_ops(0, 33'd100, 33'd7);
    push_exp(0, 33'd14, 33'd2, 1'b0, 1'b0);
    req = 4'b0001;
    @(negedge clk); #1;
    check("single_start", div_start, 1);
    check("single_grant_id", grant_id, 0);
    check("single_operands", {div_a, div_b}, {33'd100, 33'd7});
    busy_cnt = 1;
    done_at  = 0;
    n        = 0;
    while (busy && n < 40) begin
      if (done != '0) done_at = busy_cnt;
      @(negedge clk); #1;
      n++;
      if (busy) busy_cnt++;
    end
    check("single_busy_cycles", busy_cnt, 8);
    check("single_done_cycle", done_at, 8);
    check("single_drained", exp_q.size(), 0);

    // Table of single requests, including divide by zero and width extremes.
    lat = 3;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_ops(tbl[i].id, tbl[i].a, tbl[i].b);
      push_exp(tbl[i].id, tbl[i].q, tbl[i].r, tbl[i].dbz, 1'b0);
      req[tbl[i].id] = 1'b1;
      wait_drain($sformatf("vec%0d", i), 100);
    end

    // All four requesting continuously from reset: order 0,1,2,3,0.
    do_reset();
    lat       = 2;
    auto_drop = 1'b0;
    @(negedge clk);
    set_ops(0, 33'd1000, 33'd2);
    set_ops(1, 33'd1001, 33'd3);
    set_ops(2, 33'd1002, 33'd4);
    set_ops(3, 33'd1003, 33'd5);
    push_exp(0, 33'd500, 33'd0, 1'b0, 1'b0);
    push_exp(1, 33'd333, 33'd2, 1'b0, 1'b0);
    push_exp(2, 33'd250, 33'd2, 1'b0, 1'b0);
    push_exp(3, 33'd200, 33'd3, 1'b0, 1'b0);
    push_exp(0, 33'd500, 33'd0, 1'b0, 1'b0);
    req = 4'b1111;
    n   = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (exp_q.size() != 0 && n < 200);
    req       = '0;
    auto_drop = 1'b1;
    wait_drain("rr_round", 50);

    // Pointer wrap: grant 1 moves the pointer to 2; then req=0011 serves 0 then 1.
    lat = 1;
    @(negedge clk);
    set_ops(1, 33'd8, 33'd3);
    push_exp(1, 33'd2, 33'd2, 1'b0, 1'b0);
    req = 4'b0010;
    wait_drain("wrap_prep", 50);
    @(negedge clk);
    set_ops(0, 33'd9, 33'd2);
    push_exp(0, 33'd4, 33'd1, 1'b0, 1'b0);
    push_exp(1, 33'd2, 33'd2, 1'b0, 1'b0);
    req = 4'b0011;
    wait_drain("wrap_pair", 100);

    // Reset during ST_WAIT, then a pending request from requester 2.
    lat = 20;
    @(negedge clk);
    set_ops(0, 33'd50, 33'd5);
    push_exp(0, 33'd10, 33'd0, 1'b0, 1'b0);
    req = 4'b0001;
    wait_start("rst_mid", 20);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          {done, val_out, rem_out, dbz_out, to_o, busy, grant_id, div_start, div_a, div_b}, 0);
    exp_q.delete();
    req = 4'b0100;
    set_ops(2, 33'd77, 33'd7);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat   = 4;
    push_exp(2, 33'd11, 33'd0, 1'b0, 1'b0);
    wait_start("post_rst", 20);
    check("post_rst_grant_id", grant_id, 2);
    wait_drain("post_rst", 100);

`ifdef DIV_ARB_TIMEOUT_EN
    // Divider never answers: TO and done[3] 64 cycles after start, results zero.
    mute = 1'b1;
    @(negedge clk);
    set_ops(3, 33'd5, 33'd1);
    push_exp(3, 33'd0, 33'd0, 1'b0, 1'b1);
    req = 4'b1000;
    wait_start("tmo", 20);
    n = 0;
    while (done == '0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("tmo_latency", n, 64);
    wait_drain("tmo", 20);
    @(negedge clk);
    late = 1'b1;
    @(negedge clk);
    late = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("tmo_late_done_ignored", {busy, done}, 0);
    mute = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin scheduler that shares one external unsigned divider (divu_int-style start/done/valid/dbz interface) among NOF_REQ requesters, such as several average-style front ends.
- Latches the granted requester's operands, issues a single-cycle start pulse and waits for the divider's done.
- Routes quotient/remainder/flags back to the granted requester with a one-hot done pulse.
- Sits between the requesting blocks and a single divider instance.

Parameters:
NOF_BITS, 33, operand/result width (dividend, divisor, quotient, remainder)
NOF_REQ, 4, number of requesters (2..8)
TIMEOUT_LIMIT, 64, max cycles waited for div_done (only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NOF_REQ  level request per requester; held high until its done bit pulses
a_in  in  NOF_REQ*NOF_BITS  packed dividends, slice i belongs to requester i
b_in  in  NOF_REQ*NOF_BITS  packed divisors, slice i belongs to requester i
done  out  NOF_REQ  one-hot, single-cycle completion pulse to the granted requester
val_out  out  NOF_BITS  quotient, valid while done is non-zero, then held
rem_out  out  NOF_BITS  remainder, same timing as val_out
dbz_out  out  1  divide-by-zero flag, same timing as val_out
TO  out  1  single-cycle divider timeout pulse (0 when feature compiled out)
busy  out  1  high from grant until the done pulse, inclusive
grant_id  out  $clog2(NOF_REQ)  index of the current/last grant
div_start  out  1  single-cycle start pulse to the divider
div_a  out  NOF_BITS  latched dividend
div_b  out  NOF_BITS  latched divisor
div_done  in  1  divider completion pulse
div_valid  in  1  divider result valid
div_dbz  in  1  divider divide-by-zero
div_val  in  NOF_BITS  divider quotient
div_rem  in  NOF_BITS  divider remainder

Behaviour:
- Reset values: all outputs 0; state ST_IDLE; round-robin pointer rr_ptr = 0.
- Arbitration:
  - Round-robin starting at rr_ptr.
  - The winner is the first set req bit at or after rr_ptr, wrapping modulo NOF_REQ.
  - After each grant, rr_ptr = winner+1, wrapping to 0 past NOF_REQ-1.
- FSM states: ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP.
- ST_IDLE:
  - If req != 0 at edge t: latch winner's a/b into div_a/div_b and its index into grant_id; busy=1; next state ST_ISSUE.
- ST_ISSUE:
  - div_start=1 for exactly one cycle.
  - Next state ST_WAIT; wait counter cleared.
- ST_WAIT:
  - On div_done: register div_val, div_rem and div_dbz&div_valid into the outputs; go to ST_RESP.
  - div_done arriving in the same cycle as div_start is ignored.
- ST_RESP:
  - done[grant_id]=1 for one cycle; busy=1 in this cycle.
  - Next state ST_IDLE; busy=0 from the following cycle.
- Latency: req seen at edge t -> div_start high in cycle t+1 -> done pulse 1 cycle after the cycle in which div_done is seen. Overhead is 3 cycles plus divider latency.
- Requester rules:
  - The requester drops req in the cycle its done pulse is seen.
  - If req is still high in ST_IDLE, it is treated as a new request.
  - Operand changes after grant are ignored because the operands were latched.
- A req dropped before grant is never served and needs no cancel.
- Other requesters' req bits are ignored outside ST_IDLE; they wait, and none is starved (bounded by NOF_REQ grants).
- Divide by zero:
  - Forwarded from the divider as-is; the arbiter does not check b.
  - val_out/rem_out are whatever the divider returns.
- rst_n asserted mid-operation: immediate return to ST_IDLE and all outputs cleared. The external divider shares rst_n, so no orphaned done.
- val_out, rem_out, dbz_out hold their last values until the next ST_RESP.

Optional Feature:
- Macro: DIV_ARB_TIMEOUT_EN.
- Defined:
  - ST_WAIT counts cycles.
  - If the count reaches TIMEOUT_LIMIT-1 without div_done: TO pulses for 1 cycle together with done[grant_id], dbz_out=0, val_out/rem_out=0; then ST_IDLE.
  - A late div_done arriving in ST_IDLE is ignored.
- Undefined: no counter; TO tied 0; ST_WAIT waits indefinitely.

Decomposition:
- Package div_arb_pkg:
  - state enum (ST_IDLE..ST_RESP, 2 bits);
  - the default TIMEOUT_LIMIT constant;
  - a function rr_pick(req, ptr) returning the winner index.
- One sub-module, rr_arbiter: combinational winner selection plus the registered rr_ptr update on a grant-enable input. It is reusable for other shared resources.

Test Plan:
- Single request: req=0001, a=100, b=7; divider model latency 5 -> div_start 1 cycle after req, done=0001 with val_out=14, rem_out=2, dbz_out=0; busy high for 5+3 cycles.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; each done bit pulses once per round; no start pulses overlap.
- rr_ptr=2 with req=0011 -> requester 0 is granted, then requester 1; pointer wraps correctly.
- b=0, divider returns dbz=1 -> dbz_out=1 on the done pulse; next grant proceeds normally.
- rst_n pulsed low during ST_WAIT -> all outputs 0 immediately; after release, a pending req=0100 is granted cleanly.
- With DIV_ARB_TIMEOUT_EN, TIMEOUT_LIMIT=64, divider never responds -> TO and done[k] pulse 64 cycles after div_start, val_out=0; a late div_done is ignored.
